// File: rtl/serial_addsub_n.sv
// serial_addsub_n: bit-serial adder/subtractor, one bit pair per clock, LSB first.
// A single full-adder cell with a registered carry processes WIDTH bits.
// Start is taken only while idle; done pulses for one cycle when sum/c_out update.
// Optional: define SERIAL_ADDSUB_OVF_EN to add the signed overflow output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sum/c_out hold the last result
// RUN   | shifting one bit pair per clock; leaves after WIDTH edges
module serial_addsub_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDSUB_OVF_EN
   ,output logic            overflow
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] x, y, acc;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             s_bit, carry_nx;
   logic             accept, last;

   // Full-adder cell on the current LSBs plus the handshake qualifiers.
   always_comb begin
      s_bit    = x[0] ^ y[0] ^ carry;
      carry_nx = (x[0] & y[0]) | (x[0] & carry) | (y[0] & carry);
      accept   = (state == IDLE) && start;
      last     = (state == RUN) && (cnt == CNT_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   // Operand capture, serial shifting and result update.
   // Subtraction is A + ~B + (1 - c_in), so the borrow-in is folded into the carry seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         x     <= '0;
         y     <= '0;
         acc   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         c_out <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            x     <= a;
            y     <= sub ? ~b : b;
            carry <= c_in ^ sub;
            cnt   <= '0;
         end else if (state == RUN) begin
            carry <= carry_nx;
            acc   <= {s_bit, acc[WIDTH-1:1]};
            x     <= x >> 1;
            y     <= y >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
               sum   <= {s_bit, acc[WIDTH-1:1]};
               c_out <= carry_nx;
            end
         end
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   // On the final edge the registered carry is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst)       overflow <= 1'b0;
      else if (last) overflow <= carry ^ carry_nx;
   end
`endif

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: WIDTH=8 directed table and corner sequences,
// WIDTH=4 and WIDTH=32 random vectors against an arithmetic reference model.
module tb_serial_addsub_n;

   logic        clk;
   logic        rst;
   logic [31:0] a_t, b_t;
   logic        cin_t, sub_t;
   logic [2:0]  start_v, done_v, busy_v, co_v, ov_v;
   logic [7:0]  sum8;
   logic [3:0]  sum4;
   logic [31:0] sum32;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_addsub_n #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_t[7:0]), .b(b_t[7:0]),
      .c_in(cin_t), .sub(sub_t), .busy(busy_v[0]), .done(done_v[0]),
      .sum(sum8), .c_out(co_v[0])
`ifdef SERIAL_ADDSUB_OVF_EN
      ,.overflow(ov_v[0])
`endif
   );

   serial_addsub_n #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_t[3:0]), .b(b_t[3:0]),
      .c_in(cin_t), .sub(sub_t), .busy(busy_v[1]), .done(done_v[1]),
      .sum(sum4), .c_out(co_v[1])
`ifdef SERIAL_ADDSUB_OVF_EN
      ,.overflow(ov_v[1])
`endif
   );

   serial_addsub_n #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_t), .b(b_t),
      .c_in(cin_t), .sub(sub_t), .busy(busy_v[2]), .done(done_v[2]),
      .sum(sum32), .c_out(co_v[2])
`ifdef SERIAL_ADDSUB_OVF_EN
      ,.overflow(ov_v[2])
`endif
   );

`ifndef SERIAL_ADDSUB_OVF_EN
   assign ov_v = 3'b000;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] exp_sum;
      logic       exp_co;
      logic       exp_ov;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_sum(input int sel);
      case (sel)
         0:       return {24'd0, sum8};
         1:       return {28'd0, sum4};
         default: return sum32;
      endcase
   endfunction

   // Reference: plain integer arithmetic on the unsigned and signed views.
   function automatic void ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                     input logic ci, input logic sb,
                                     output logic [31:0] s, output logic co, output logic ov);
      longint ua, ub, uc, full, half, r, sa, sbv, sr;
      ua   = longint'(av);
      ub   = longint'(bv);
      uc   = ci ? 64'sd1 : 64'sd0;
      full = longint'(1) << w;
      half = longint'(1) << (w - 1);
      if (!sb) begin
         r  = ua + ub + uc;
         co = (r >= full);
         if (r >= full) r = r - full;
      end else begin
         r  = ua - ub - uc;
         co = (r >= 0);
         if (r < 0) r = r + full;
      end
      s   = r[31:0];
      sa  = (ua >= half) ? ua - full : ua;
      sbv = (ub >= half) ? ub - full : ub;
      sr  = sb ? (sa - sbv - uc) : (sa + sbv + uc);
      ov  = (sr >= half) || (sr < -half);
   endfunction

   // One isolated operation; lat is the cycle index of done with the start cycle as 0.
   task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb,
                         output logic [31:0] s, output logic co, output logic ov, output int lat);
      @(negedge clk);
      a_t = av; b_t = bv; cin_t = ci; sub_t = sb;
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
      lat = 1;
      while (!done_v[sel] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      s  = get_sum(sel);
      co = co_v[sel];
      ov = ov_v[sel];
      @(negedge clk);
      check("done_one_cycle", {63'd0, done_v[sel]}, 64'd0);
   endtask

   initial begin
      logic [31:0] s, es, msk;
      logic        co, ov, eco, eov;
      logic        saw_done;
      int          lat, w, c0, n;
      int          t_done [3];

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

      rst = 1'b1; start_v = 3'b000; a_t = '0; b_t = '0; cin_t = 1'b0; sub_t = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_busy",  {63'd0, busy_v[i]}, 64'd0);
         check("reset_done",  {63'd0, done_v[i]}, 64'd0);
         check("reset_sum",   {32'd0, get_sum(i)}, 64'd0);
         check("reset_c_out", {63'd0, co_v[i]}, 64'd0);
      end
      rst = 1'b0;

      // Directed table, WIDTH=8.
      for (int i = 0; i < 9; i++) begin
         run_op(0, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
         check("tbl_sum",     {32'd0, s}, {56'd0, vecs[i].exp_sum});
         check("tbl_c_out",   {63'd0, co}, {63'd0, vecs[i].exp_co});
         check("tbl_latency", 64'(lat), 64'd9);
`ifdef SERIAL_ADDSUB_OVF_EN
         check("tbl_overflow", {63'd0, ov}, {63'd0, vecs[i].exp_ov});
`endif
      end

      // Back-to-back with start held high: next operands presented in each done cycle.
      @(negedge clk);
      a_t = 32'h01; b_t = 32'h02; cin_t = 1'b0; sub_t = 1'b0; start_v[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         @(negedge clk);
         while (!done_v[0] && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("b2b_done_seen", {63'd0, done_v[0]}, 64'd1);
         t_done[k] = cyc;
         case (k)
            0: begin check("b2b_sum0", {56'd0, sum8}, 64'h03); a_t = 32'h10; b_t = 32'h20; end
            1: begin check("b2b_sum1", {56'd0, sum8}, 64'h30); a_t = 32'hAA; b_t = 32'h55; end
            default: begin check("b2b_sum2", {56'd0, sum8}, 64'hFF); start_v[0] = 1'b0; end
         endcase
      end
      check("b2b_spacing01", 64'(t_done[1] - t_done[0]), 64'd9);
      check("b2b_spacing12", 64'(t_done[2] - t_done[1]), 64'd9);

      // Start and operand changes while busy are ignored.
      @(negedge clk);
      @(negedge clk);
      a_t = 32'h12; b_t = 32'h34; cin_t = 1'b0; sub_t = 1'b0; start_v[0] = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("busy_after_start", {63'd0, busy_v[0]}, 64'd1);
      check("sum_holds_in_run", {56'd0, sum8}, 64'hFF);
      @(negedge clk);
      @(negedge clk);
      a_t = 32'hFF; b_t = 32'hFF; sub_t = 1'b1; cin_t = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0; a_t = 32'h77;
      n = 0;
      while (!done_v[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ign_sum",     {56'd0, sum8}, 64'h46);
      check("ign_c_out",   {63'd0, co_v[0]}, 64'd0);
      check("ign_latency", 64'(cyc - c0), 64'd9);
      @(negedge clk);
      check("ign_no_second", {63'd0, done_v[0]}, 64'd0);

      // Reset in RUN cycle 4 aborts the operation.
      a_t = 32'h21; b_t = 32'h03; sub_t = 1'b0; cin_t = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",  {63'd0, busy_v[0]}, 64'd0);
      check("abort_done",  {63'd0, done_v[0]}, 64'd0);
      check("abort_sum",   {56'd0, sum8}, 64'd0);
      check("abort_c_out", {63'd0, co_v[0]}, 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_v[0]) saw_done = 1'b1;
      end
      check("abort_no_done", {63'd0, saw_done}, 64'd0);

      // Random vectors on all three widths against the reference model.
      for (int sel = 0; sel < 3; sel++) begin
         w   = (sel == 0) ? 8 : (sel == 1) ? 4 : 32;
         msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
         for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rs;
            ra = $urandom() & msk;
            rb = $urandom() & msk;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            run_op(sel, ra, rb, rc, rs, s, co, ov, lat);
            ref_model(w, ra, rb, rc, rs, es, eco, eov);
            check("rnd_sum",     {32'd0, s}, {32'd0, es});
            check("rnd_c_out",   {63'd0, co}, {63'd0, eco});
            check("rnd_latency", 64'(lat), 64'(w + 1));
`ifdef SERIAL_ADDSUB_OVF_EN
            check("rnd_overflow", {63'd0, ov}, {63'd0, eov});
`endif
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
